// File: rtl/comp_nibble_serial.sv
// comp_nibble_serial
// Serial magnitude comparator. It compares two WIDTH-bit operands one nibble
// per clock, starting from the most significant nibble. It supports unsigned
// and two's-complement compares, and uses cascade inputs to break ties when
// the operands are equal.
//
// Ports
//   clk                         rising-edge clock
//   rst_n                       asynchronous active-low reset
//   start                       request a compare (sampled when not busy)
//   signed_mode                 1 = two's-complement, 0 = unsigned
//   a, b                        operands
//   cas_lt_in/cas_eq_in/cas_gt_in  cascade inputs, used only when a == b
//   busy                        compare in progress
//   done                        one-cycle pulse when the result is written
//   a_lt_b/a_eq_b/a_gt_b        registered result
module comp_nibble_serial #(
    parameter int WIDTH      = 16,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cas_lt_in,
    input  logic             cas_eq_in,
    input  logic             cas_gt_in,
    output logic             busy,
    output logic             done,
    output logic             a_lt_b,
    output logic             a_eq_b,
    output logic             a_gt_b
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] TOP_IDX  = IW'(N - 1);
    localparam logic [IW-1:0] ZERO_IDX = IW'(0);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic            sgn_r, cas_lt_r, cas_eq_r, cas_gt_r;
    logic [IW-1:0]   idx_r;
    logic            decided_r, dec_gt_r;
    logic            busy_r, done_r, lt_r, eq_r, gt_r;

    logic [3:0]      raw_a_s, raw_b_s, nib_a_s, nib_b_s;
    logic            flip_s, nib_ne_s, nib_gt_s;
    logic            dec_s, dec_gt_s, last_s, accept_s;
    logic [2:0]      res_s;

    // Result encoding {lt, eq, gt}. A nibble decision wins. Otherwise the
    // cascade inputs decide: eq_in dominates, and then the lt/gt pair maps
    // straight through. Both lt and gt set gives all zero; neither set gives
    // lt=gt=1.
    function automatic logic [2:0] resolve(input logic dec, input logic gt,
                                           input logic clt, input logic ceq,
                                           input logic cgt);
        logic [2:0] r;
        if (dec) begin
            r = gt ? 3'b001 : 3'b100;
        end else if (ceq) begin
            r = 3'b010;
        end else begin
            case ({clt, cgt})
                2'b10:   r = 3'b100;
                2'b01:   r = 3'b001;
                2'b11:   r = 3'b000;
                default: r = 3'b101;
            endcase
        end
        return r;
    endfunction

    // Nibble compare, decision tracking and next-state logic.
    always_comb begin
        raw_a_s  = 4'(a_r >> {idx_r, 2'b00});
        raw_b_s  = 4'(b_r >> {idx_r, 2'b00});
        // Flipping the sign bit of the top nibble turns a two's-complement
        // order into an unsigned order.
        flip_s   = sgn_r && (idx_r == TOP_IDX);
        nib_a_s  = {raw_a_s[3] ^ flip_s, raw_a_s[2:0]};
        nib_b_s  = {raw_b_s[3] ^ flip_s, raw_b_s[2:0]};
        nib_ne_s = (nib_a_s != nib_b_s);
        nib_gt_s = (nib_a_s > nib_b_s);
        // The first unequal nibble is sticky. Later nibbles cannot overturn it.
        dec_s    = decided_r | nib_ne_s;
        dec_gt_s = decided_r ? dec_gt_r : nib_gt_s;
        last_s   = (idx_r == ZERO_IDX) || ((EARLY_EXIT != 0) && nib_ne_s);
        res_s    = resolve(dec_s, dec_gt_s, cas_lt_r, cas_eq_r, cas_gt_r);
        // DONE accepts a new start the same way IDLE does, so there is no
        // dead cycle between back-to-back compares.
        accept_s = start && (state_r != RUN);
        state_nx = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Operand latch, nibble walk, and registered status and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            sgn_r     <= 1'b0;
            cas_lt_r  <= 1'b0;
            cas_eq_r  <= 1'b0;
            cas_gt_r  <= 1'b0;
            idx_r     <= ZERO_IDX;
            decided_r <= 1'b0;
            dec_gt_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            lt_r      <= 1'b0;
            eq_r      <= 1'b0;
            gt_r      <= 1'b0;
        end else begin
            busy_r <= (state_nx == RUN);
            done_r <= (state_r == RUN) && last_s;
            if (accept_s) begin
                a_r       <= a;
                b_r       <= b;
                sgn_r     <= signed_mode;
                cas_lt_r  <= cas_lt_in;
                cas_eq_r  <= cas_eq_in;
                cas_gt_r  <= cas_gt_in;
                idx_r     <= TOP_IDX;
                decided_r <= 1'b0;
                dec_gt_r  <= 1'b0;
            end else if (state_r == RUN) begin
                idx_r     <= idx_r - ONE_IDX;
                decided_r <= dec_s;
                dec_gt_r  <= dec_gt_s;
                if (last_s) begin
                    {lt_r, eq_r, gt_r} <= res_s;
                end
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign a_lt_b = lt_r;
    assign a_eq_b = eq_r;
    assign a_gt_b = gt_r;
endmodule

// File: doc/comp_nibble_serial.md
COMP_NIBBLE_SERIAL -- requirements
Module: comp_nibble_serial

Interface
REQ-001 SHALL have parameter WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
REQ-002 SHALL have parameter EARLY_EXIT, 1; 1 = finish on the first unequal nibble, 0 = always scan all nibbles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request a comparison; sampled only when idle.
REQ-006 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have ports cas_lt_in, cas_eq_in, cas_gt_in  input  1 each  cascade inputs, used only when A equals B.
REQ-010 SHALL have port busy  output  1  comparison in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a result is written.
REQ-012 SHALL have ports a_lt_b, a_eq_b, a_gt_b  output  1 each  registered result.

Function
REQ-013 SHALL use N = WIDTH/4 nibbles, indexed N-1 (most significant) down to 0.
REQ-014 SHALL use FSM states IDLE, RUN and DONE; reset enters IDLE.
REQ-015 In IDLE with start=1 at an edge, SHALL latch a, b, signed_mode and the cascade inputs, set the index to N-1, go to RUN and drive busy=1 from that edge.
REQ-016 SHALL ignore start while busy=1, and latched operands SHALL NOT change during RUN.
REQ-017 In RUN, SHALL compare exactly one latched nibble per clock, at the current index, as a 4-bit magnitude compare.
REQ-018 When signed_mode=1, SHALL invert bit 3 of both operands' nibble N-1 before comparing it; other nibbles are compared unchanged.
REQ-019 SHALL record the first unequal nibble as the decision (gt or lt); later nibbles SHALL NOT alter it.
REQ-020 With EARLY_EXIT=1, SHALL finish at the edge where the first unequal nibble is found; finishing at index i gives a latency of N-i cycles from the start edge.
REQ-021 With EARLY_EXIT=0, SHALL finish after nibble 0 in all cases; latency is exactly N cycles.
REQ-022 If all nibbles are equal, the result SHALL follow the cascade rule:
  - cas_eq_in=1 gives eq=1 only;
  - gt_in=1, lt_in=0 gives gt=1 only;
  - lt_in=1, gt_in=0 gives lt=1 only;
  - gt_in=lt_in=1 gives all outputs 0;
  - gt_in=lt_in=0 gives gt=1, lt=1, eq=0.
REQ-023 At the finishing edge, SHALL write the three outputs, drive done=1 for exactly one cycle (DONE state), then return to IDLE with busy=0.
REQ-024 SHALL accept start asserted during the DONE cycle on the next edge; no dead cycle follows DONE.
REQ-025 Result outputs SHALL hold their previous value throughout RUN and change only at a finishing edge.
REQ-026 For every non-cascade result, exactly one of lt, eq and gt SHALL be 1.

Reset
REQ-027 rst_n=0 SHALL immediately force the FSM to IDLE and drive busy=0, done=0, a_lt_b=0, a_eq_b=0, a_gt_b=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the next start SHALL begin a fresh compare.

Verification
REQ-029 SHALL cover these directed scenarios, all with WIDTH=16:
  - A=0x5555, B=0x5555, cas_eq_in=1 -> a_eq_b=1; done 4 cycles after start, for either EARLY_EXIT value.
  - A=0x8200, B=0x7FFF, unsigned, EARLY_EXIT=1 -> a_gt_b=1, done 1 cycle after start. Same operands with signed_mode=1 -> a_lt_b=1, 1 cycle.
  - A=0x1234, B=0x1235, EARLY_EXIT=1 -> a_lt_b=1, done 4 cycles after start. A=0xCD00, B=0xCE00, EARLY_EXIT=0 -> a_lt_b=1, done 4 cycles after start.
  - A=B=0xABAB with cascade (lt,eq,gt) = (0,0,1) -> gt only; with (1,0,1) -> all 0; with (0,0,0) -> lt=1, gt=1, eq=0.
  - start re-pulsed while busy -> ignored; start held through the DONE cycle -> new compare accepted back-to-back; outputs stable during RUN.
  - rst_n pulsed low two cycles into a 4-cycle compare -> outputs 0, busy 0, no done; a subsequent A=0xFF00, B=0x00FF compare -> a_gt_b=1.
